// File: rtl/first_nios2_system_led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM block.
// Optional soft-ramp behaviour is selected with LED_PWM_SOFT_RAMP_EN.
package first_nios2_system_led_pwm_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned PRESC_W    = 16;
    localparam logic [DATA_WIDTH-1:0] PWM_MAX = 8'd254;

    typedef logic [DATA_WIDTH-1:0] duty_t;
    typedef logic [PRESC_W-1:0]    presc_t;

    // One unit step of cur toward tgt; used by the soft-ramp shadow update.
    function automatic duty_t ramp_step(input duty_t cur, input duty_t tgt);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + duty_t'(1);
        end else if (cur > tgt) begin
            res = cur - duty_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/first_nios2_system_led_pwm_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE_DIV clocks while enabled.
// Counter is held at zero while disabled so a re-enable starts a fresh tick interval.
module first_nios2_system_led_pwm_prescaler
    import first_nios2_system_led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam presc_t DIV_M1 = presc_t'(PRESCALE_DIV - 1);

    presc_t presc_cnt_q;
    presc_t presc_cnt_d;

    always_comb begin
        tick        = enable && (presc_cnt_q == DIV_M1);
        presc_cnt_d = presc_cnt_q;
        if (!enable || tick) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + presc_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/first_nios2_system_led_pwm.sv
// LED PWM driven by the PIO duty byte; duty is shadowed and only updated at period wrap.
// Define LED_PWM_SOFT_RAMP_EN to step the shadow duty by one per period instead of jumping.
module first_nios2_system_led_pwm
    import first_nios2_system_led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 50
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    input  logic                  enable,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [DATA_WIDTH-1:0] duty_active
);

    logic  tick;
    logic  wrap;
    duty_t pwm_cnt_q,  pwm_cnt_d;
    duty_t duty_q,     duty_d;
    logic  pwm_q,      pwm_d;
    logic  ps_q,       ps_d;

    first_nios2_system_led_pwm_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    always_comb begin
        wrap      = tick && (pwm_cnt_q == PWM_MAX);
        pwm_cnt_d = pwm_cnt_q;
        duty_d    = duty_q;
        if (!enable) begin
            pwm_cnt_d = '0;
`ifdef LED_PWM_SOFT_RAMP_EN
            duty_d    = '0;
`else
            duty_d    = in_port;
`endif
        end else if (tick) begin
            if (wrap) begin
                pwm_cnt_d = '0;
`ifdef LED_PWM_SOFT_RAMP_EN
                duty_d    = ramp_step(duty_q, in_port);
`else
                duty_d    = in_port;
`endif
            end else begin
                pwm_cnt_d = pwm_cnt_q + duty_t'(1);
            end
        end
        ps_d  = wrap;
        // Compare against the values being loaded so the output lines up with the counter.
        pwm_d = enable && (pwm_cnt_d < duty_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_first_nios2_system_led_pwm.sv
// Bench for the LED PWM: two instances (divide-by-2 and divide-by-1) against an elapsed-time model.
module tb_first_nios2_system_led_pwm;

    localparam int unsigned DIV_M [2] = '{2, 1};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] in_port = 8'd0;

    logic       pwm_a, ps_a, pwm_b, ps_b;
    logic [7:0] duty_a, duty_b;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    bit          chk_on = 1'b0;

    int unsigned el_m   [2];
    int unsigned duty_m [2];
    bit          pwm_m  [2];
    bit          ps_m   [2];

    always #5 clk = ~clk;

    first_nios2_system_led_pwm #(.PRESCALE_DIV(2)) u_dut_a (
        .clk (clk), .reset_n (reset_n), .in_port (in_port), .enable (enable),
        .pwm_out (pwm_a), .period_start (ps_a), .duty_active (duty_a)
    );

    first_nios2_system_led_pwm #(.PRESCALE_DIV(1)) u_dut_b (
        .clk (clk), .reset_n (reset_n), .in_port (in_port), .enable (enable),
        .pwm_out (pwm_b), .period_start (ps_b), .duty_active (duty_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: counter position is (enabled clocks since start / DIV) mod 255,
    // a wrap happens whenever a whole period of 255*DIV clocks has elapsed.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ps_m[k] = 1'b0;
            if (!reset_n) begin
                el_m[k]   = 0;
                duty_m[k] = 0;
                pwm_m[k]  = 1'b0;
            end else if (!enable) begin
                el_m[k]  = 0;
                pwm_m[k] = 1'b0;
`ifdef LED_PWM_SOFT_RAMP_EN
                duty_m[k] = 0;
`else
                duty_m[k] = in_port;
`endif
            end else begin
                el_m[k]++;
                if (el_m[k] % (255 * DIV_M[k]) == 0) begin
                    ps_m[k] = 1'b1;
`ifdef LED_PWM_SOFT_RAMP_EN
                    if (duty_m[k] < in_port) duty_m[k]++;
                    else if (duty_m[k] > in_port) duty_m[k]--;
`else
                    duty_m[k] = in_port;
`endif
                end
                pwm_m[k] = ((el_m[k] / DIV_M[k]) % 255) < duty_m[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_a",  pwm_a,  pwm_m[0]);
            check("ps_a",   ps_a,   ps_m[0]);
            check("duty_a", duty_a, duty_m[0]);
            check("pwm_b",  pwm_b,  pwm_m[1]);
            check("ps_b",   ps_b,   ps_m[1]);
            check("duty_b", duty_b, duty_m[1]);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ps(input bit sel_b, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = sel_b ? ps_b : ps_a;
        end
        if (!seen) check(sel_b ? "ps_b_timeout" : "ps_a_timeout", 0, 1);
    endtask

    initial begin
        int hi_cnt;
        int ps_cnt;
        int exp_hi;
        int r;

        reset_n = 1'b0;
        enable  = 1'b0;
        in_port = 8'd64;
        run(3);
        chk_on = 1'b1;
        check("rst_duty_a", duty_a, 0);
        check("rst_pwm_a",  pwm_a,  0);
        check("rst_ps_b",   ps_b,   0);

        // Duty captured while disabled then released.
        reset_n = 1'b1;
        run(2);
        enable = 1'b1;
        wait_ps(1'b0, 1200);
        exp_hi = int'(duty_m[0]) * 2;
        hi_cnt = 0;
        ps_cnt = 0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            hi_cnt += int'(pwm_a);
            ps_cnt += int'(ps_a);
        end
        check("hi_cnt_a", hi_cnt, exp_hi);
        check("ps_cnt_a", ps_cnt, 1);

        // Duty extremes.
        in_port = 8'd0;
        run(600);
        in_port = 8'd255;
        run(1100);

        // Mid-period change: ignored until the next wrap.
        in_port = 8'd64;
        wait_ps(1'b0, 1200);
        run(200);
        in_port = 8'd200;
        run(1100);

        // Disable at pwm_cnt=30 of the divide-by-1 instance, re-enable after 10 clocks.
        wait_ps(1'b1, 600);
        run(30);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pwm_b", pwm_b, 0);
        run(9);
        enable = 1'b1;
        run(600);

        // Single-cycle reset mid-period with duty 128.
        in_port = 8'd128;
        run(800);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_duty_b", duty_b, 0);
        reset_n = 1'b1;
        in_port = 8'd40;
        run(700);

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      in_port = 8'd0;
            else if (r < 20) in_port = 8'd255;
            else             in_port = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 12) begin
                enable = ~enable;
            end else if (r < 18) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            run($urandom_range(1, 600));
        end
        enable = 1'b1;
        run(600);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
